// File: rtl/prog_fetch.sv
// prog_fetch: instruction-fetch front end for the nibble-processor family.
//
// This block combines three pieces of the fetch path:
//   - the program counter,
//   - the issue side of a synchronous program-memory port (1-cycle read latency),
//   - a 2-entry {word, addr} buffer toward decode, using a valid/ready handshake.
// It sustains one instruction per cycle. Jumps flush the buffer and any read in flight.
//
// Optional feature (define the macro to enable it):
//   PROG_FETCH_HALT_AT_END_EN
//     Issuing the last address (all ones) sets 'halted' and stops further issue.
//     Only a jump or a reset clears 'halted'.
//     Without the macro, pc wraps around and 'halted' is tied low.
//
// Parameters:
//   ADDR_W  program-counter / memory address width
//   WORD_W  program word width
//   OPC_W   opcode width (upper word bits); operand is WORD_W-OPC_W bits, which must be >= 1
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous, active-high reset
//   run          fetch enable; low stops new memory reads
//   jump         load pc from jump_addr and flush the buffer and the in-flight read
//   jump_addr    jump target
//   mem_en       memory read strobe
//   mem_addr     memory read address (always equals pc)
//   mem_rdata    read data, valid the cycle after mem_en
//   instr_valid  buffer head holds an instruction
//   instr_ready  decode accepts the head this cycle
//   opcode       head word upper OPC_W bits (0 when empty)
//   operand      head word lower bits (0 when empty)
//   instr_pc     fetch address of the head word (0 when empty)
//   pc           next address to issue
//   halted       end-of-program stop flag

module prog_fetch #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned WORD_W = 8,
  parameter int unsigned OPC_W  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    run,
  input  logic                    jump,
  input  logic [ADDR_W-1:0]       jump_addr,
  output logic                    mem_en,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [WORD_W-1:0]       mem_rdata,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  output logic [OPC_W-1:0]        opcode,
  output logic [WORD_W-OPC_W-1:0] operand,
  output logic [ADDR_W-1:0]       instr_pc,
  output logic [ADDR_W-1:0]       pc,
  output logic                    halted
);

  localparam int unsigned OpdW = WORD_W - OPC_W;
  localparam logic [ADDR_W-1:0] LastAddr = {ADDR_W{1'b1}};

  // Program counter and the single outstanding read.
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pending_q, pending_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;

  // Buffer: entry 0 is always the head; entry 1 sits behind it.
  logic [WORD_W-1:0] word0_q, word0_d, word1_q, word1_d;
  logic [ADDR_W-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
  logic [1:0]        count_q, count_d;

  logic       pop;
  logic       land;
  logic       issue;
  logic [2:0] occupancy;
  logic [1:0] base_count;

  assign instr_valid = (count_q != 2'd0);
  assign pop         = instr_valid && instr_ready;
  // A jump discards whatever is arriving this cycle.
  assign land        = pending_q && !jump;

  // Slots committed after this cycle, counting the in-flight read.
  // pop implies count_q >= 1, so the subtraction cannot underflow.
  assign occupancy = {1'b0, count_q} + {2'b00, pending_q} - {2'b00, pop};

  // Gated by reset so the strobe reads 0 while reset is held,
  // even with run high.
  assign issue = !reset && run && !jump && !halted && (occupancy < 3'd2);

  assign mem_en   = issue;
  assign mem_addr = pc_q;
  assign pc       = pc_q;

  // Head fields are forced to 0 while the buffer is empty.
  assign opcode   = instr_valid ? word0_q[WORD_W-1 -: OPC_W] : '0;
  assign operand  = instr_valid ? word0_q[OpdW-1:0]          : '0;
  assign instr_pc = instr_valid ? addr0_q                    : '0;

  // ---------------------------------------------------------------------------
  // Program counter and in-flight read tracking
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_d        = pc_q;
    pending_d   = issue;
    pend_addr_d = pend_addr_q;
    if (jump) begin
      pc_d = jump_addr;
    end else if (issue) begin
      // Modulo-2^ADDR_W increment; wraps naturally at LastAddr.
      pc_d        = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      pend_addr_d = pc_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q        <= '0;
      pending_q   <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      pc_q        <= pc_d;
      pending_q   <= pending_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Instruction buffer
  // ---------------------------------------------------------------------------
  // A pop shifts entry 1 forward first. A landing word then goes to the first
  // free slot after that shift, so a simultaneous land and pop keeps order.
  always_comb begin
    word0_d    = word0_q;
    word1_d    = word1_q;
    addr0_d    = addr0_q;
    addr1_d    = addr1_q;
    count_d    = count_q;
    base_count = count_q - {1'b0, pop};

    if (jump) begin
      // Any same-cycle pop has already been accepted by decode; drop the rest.
      count_d = 2'd0;
    end else begin
      if (pop) begin
        word0_d = word1_q;
        addr0_d = addr1_q;
      end
      if (land) begin
        if (base_count == 2'd0) begin
          word0_d = mem_rdata;
          addr0_d = pend_addr_q;
        end else begin
          // The issue condition guarantees base_count is 1 here, never 2.
          word1_d = mem_rdata;
          addr1_d = pend_addr_q;
        end
      end
      count_d = base_count + {1'b0, land};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word0_q <= '0;
      word1_q <= '0;
      addr0_q <= '0;
      addr1_q <= '0;
      count_q <= 2'd0;
    end else begin
      word0_q <= word0_d;
      word1_q <= word1_d;
      addr0_q <= addr0_d;
      addr1_q <= addr1_d;
      count_q <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // End-of-program halt
  // ---------------------------------------------------------------------------
`ifdef PROG_FETCH_HALT_AT_END_EN
  logic halted_q, halted_d;

  always_comb begin
    halted_d = halted_q;
    if (jump) begin
      halted_d = 1'b0;
    end else if (issue && (pc_q == LastAddr)) begin
      // The last word is still in flight and will be delivered normally.
      halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_prog_fetch.sv
// Directed bench for prog_fetch.
// The memory model returns word = address[7:0], one cycle after mem_en.
// When mem_en is low it returns 8'hEE, so any stale landing shows up as wrong data.
// Inputs are driven on the falling edge. Outputs are checked 1 time unit later.

module tb_prog_fetch;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned WORD_W = 8;
  localparam int unsigned OPC_W  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              run = 1'b0;
  logic              jump = 1'b0;
  logic [ADDR_W-1:0] jump_addr = '0;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_rdata = 8'hEE;
  logic              instr_valid;
  logic              instr_ready = 1'b0;
  logic [OPC_W-1:0]  opcode;
  logic [WORD_W-OPC_W-1:0] operand;
  logic [ADDR_W-1:0] instr_pc;
  logic [ADDR_W-1:0] pc;
  logic              halted;

  int checks = 0;
  int errors = 0;

  prog_fetch #(
    .ADDR_W(ADDR_W),
    .WORD_W(WORD_W),
    .OPC_W (OPC_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .jump       (jump),
    .jump_addr  (jump_addr),
    .mem_en     (mem_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .opcode     (opcode),
    .operand    (operand),
    .instr_pc   (instr_pc),
    .pc         (pc),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  // Synchronous program ROM
  always @(posedge clk) mem_rdata <= mem_en ? mem_addr[7:0] : 8'hEE;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check the fetch-side and decode-side outputs for one cycle.
  // The expected head fields come from ipc through the memory model.
  task automatic expect_cyc(input string tag, input logic en, input logic [ADDR_W-1:0] addr,
                            input logic valid, input logic [ADDR_W-1:0] ipc);
    logic [7:0] w;
    w = valid ? ipc[7:0] : 8'h00;
    chk({tag, ".mem_en"},      32'(mem_en),      32'(en));
    chk({tag, ".mem_addr"},    32'(mem_addr),    32'(addr));
    chk({tag, ".pc"},          32'(pc),          32'(addr));
    chk({tag, ".instr_valid"}, 32'(instr_valid), 32'(valid));
    chk({tag, ".instr_pc"},    32'(instr_pc),    32'(valid ? ipc : 12'h000));
    chk({tag, ".opcode"},      32'(opcode),      32'(w[7:4]));
    chk({tag, ".operand"},     32'(operand),     32'(w[3:0]));
  endtask

  initial begin
    // Reset held with run high: everything must read zero.
    run = 1'b1;
    instr_ready = 1'b1;
    #1;
    expect_cyc("rst", 1'b0, 12'h000, 1'b0, 12'h000);
    chk("rst.halted", 32'(halted), 32'd0);

    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1 expect_cyc("c0", 1'b1, 12'h000, 1'b0, 12'h000);
    @(negedge clk);
    #1 expect_cyc("c1", 1'b1, 12'h001, 1'b0, 12'h000);

    // Streaming: the head trails the issue address by two.
    for (int c = 2; c < 20; c++) begin
      @(negedge clk);
      #1 expect_cyc($sformatf("c%0d", c), 1'b1, 12'(c), 1'b1, 12'(c - 2));
    end

    // Decode stalls for 5 cycles. The buffer fills and issue stops.
    for (int c = 20; c < 25; c++) begin
      @(negedge clk);
      instr_ready = 1'b0;
      #1 expect_cyc($sformatf("c%0d", c), 1'b0, 12'h014, 1'b1, 12'h012);
    end

    // Release: issue resumes in the same cycle as the first pop, and no word is lost.
    for (int c = 25; c < 31; c++) begin
      @(negedge clk);
      instr_ready = 1'b1;
      #1 expect_cyc($sformatf("c%0d", c), 1'b1, 12'(c - 5), 1'b1, 12'(c - 7));
    end

    // Jump while a read is in flight and decode is stalled.
    @(negedge clk);
    instr_ready = 1'b0;
    jump = 1'b1;
    jump_addr = 12'h3A0;
    #1 expect_cyc("c31", 1'b0, 12'h01A, 1'b1, 12'h018);
    @(negedge clk);
    jump = 1'b0;
    instr_ready = 1'b1;
    #1 expect_cyc("c32", 1'b1, 12'h3A0, 1'b0, 12'h000);
    @(negedge clk);
    #1 expect_cyc("c33", 1'b1, 12'h3A1, 1'b0, 12'h000);
    @(negedge clk);
    #1 expect_cyc("c34", 1'b1, 12'h3A2, 1'b1, 12'h3A0);
    @(negedge clk);
    #1 expect_cyc("c35", 1'b1, 12'h3A3, 1'b1, 12'h3A1);

    // Fill the buffer, then jump and pop in the same cycle.
    @(negedge clk);
    instr_ready = 1'b0;
    #1 expect_cyc("c36", 1'b0, 12'h3A4, 1'b1, 12'h3A2);
    @(negedge clk);
    #1 expect_cyc("c37", 1'b0, 12'h3A4, 1'b1, 12'h3A2);
    @(negedge clk);
    instr_ready = 1'b1;
    jump = 1'b1;
    jump_addr = 12'h050;
    #1 expect_cyc("c38", 1'b0, 12'h3A4, 1'b1, 12'h3A2);
    @(negedge clk);
    jump = 1'b0;
    #1 expect_cyc("c39", 1'b1, 12'h050, 1'b0, 12'h000);
    @(negedge clk);
    #1 expect_cyc("c40", 1'b1, 12'h051, 1'b0, 12'h000);
    @(negedge clk);
    #1 expect_cyc("c41", 1'b1, 12'h052, 1'b1, 12'h050);

    // Run up to the top of the address space.
    @(negedge clk);
    jump = 1'b1;
    jump_addr = 12'hFFE;
    #1 expect_cyc("c42", 1'b0, 12'h053, 1'b1, 12'h051);
    @(negedge clk);
    jump = 1'b0;
    #1 expect_cyc("c43", 1'b1, 12'hFFE, 1'b0, 12'h000);
    @(negedge clk);
    #1 expect_cyc("c44", 1'b1, 12'hFFF, 1'b0, 12'h000);
    chk("c44.halted", 32'(halted), 32'd0);
`ifdef PROG_FETCH_HALT_AT_END_EN
    @(negedge clk);
    #1 expect_cyc("c45", 1'b0, 12'h000, 1'b1, 12'hFFE);
    chk("c45.halted", 32'(halted), 32'd1);
    @(negedge clk);
    #1 expect_cyc("c46", 1'b0, 12'h000, 1'b1, 12'hFFF);
    @(negedge clk);
    #1 expect_cyc("c47", 1'b0, 12'h000, 1'b0, 12'h000);
    chk("c47.halted", 32'(halted), 32'd1);
    @(negedge clk);
    #1 expect_cyc("c48", 1'b0, 12'h000, 1'b0, 12'h000);
    @(negedge clk);
    jump = 1'b1;
    jump_addr = 12'h100;
    #1 expect_cyc("c49", 1'b0, 12'h000, 1'b0, 12'h000);
    chk("c49.halted", 32'(halted), 32'd1);
`else
    @(negedge clk);
    #1 expect_cyc("c45", 1'b1, 12'h000, 1'b1, 12'hFFE);
    chk("c45.halted", 32'(halted), 32'd0);
    @(negedge clk);
    #1 expect_cyc("c46", 1'b1, 12'h001, 1'b1, 12'hFFF);
    @(negedge clk);
    #1 expect_cyc("c47", 1'b1, 12'h002, 1'b1, 12'h000);
    @(negedge clk);
    #1 expect_cyc("c48", 1'b1, 12'h003, 1'b1, 12'h001);
    @(negedge clk);
    jump = 1'b1;
    jump_addr = 12'h100;
    #1 expect_cyc("c49", 1'b0, 12'h004, 1'b1, 12'h002);
`endif
    @(negedge clk);
    jump = 1'b0;
    #1 expect_cyc("c50", 1'b1, 12'h100, 1'b0, 12'h000);
    chk("c50.halted", 32'(halted), 32'd0);
    @(negedge clk);
    #1 expect_cyc("c51", 1'b1, 12'h101, 1'b0, 12'h000);
    @(negedge clk);
    #1 expect_cyc("c52", 1'b1, 12'h102, 1'b1, 12'h100);

    // Asynchronous reset mid-cycle, with a valid head and a read in flight.
    #2 reset = 1'b1;
    #1 expect_cyc("rst_mid", 1'b0, 12'h000, 1'b0, 12'h000);
    chk("rst_mid.halted", 32'(halted), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 expect_cyc("r0", 1'b1, 12'h000, 1'b0, 12'h000);
    @(negedge clk);
    #1 expect_cyc("r1", 1'b1, 12'h001, 1'b0, 12'h000);
    @(negedge clk);
    #1 expect_cyc("r2", 1'b1, 12'h002, 1'b1, 12'h000);

    // run low: the in-flight read still lands and the buffer drains.
    @(negedge clk);
    run = 1'b0;
    #1 expect_cyc("r3", 1'b0, 12'h003, 1'b1, 12'h001);
    @(negedge clk);
    #1 expect_cyc("r4", 1'b0, 12'h003, 1'b1, 12'h002);
    @(negedge clk);
    #1 expect_cyc("r5", 1'b0, 12'h003, 1'b0, 12'h000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
